// File: rtl/rgb_pkg.sv
// rgb_pkg: shared constants and types for the RGB PWM brightness stage.
// Channel indices follow the SB_RGBA_DRV pin mapping (RGB2=red, RGB1=green,
// RGB0=blue) so per-channel vectors line up with the driver inputs.
package rgb_pkg;

  // Default duty / period-counter width; the period is 2**PWM_BITS ticks.
  localparam int PWM_BITS_DFLT = 8;

  // Default prescaler: 6 MHz / 23 / 256 gives a PWM rate of about 1.02 kHz.
  localparam int PRESC_DFLT = 23;

  // Prescaler register width; PRESC is limited to 1..65535.
  localparam int PRESC_W = 16;

  localparam int NUM_CH = 3;
  localparam int CH_R   = 2;
  localparam int CH_G   = 1;
  localparam int CH_B   = 0;

  typedef logic [PWM_BITS_DFLT-1:0] duty_t;

  typedef struct packed {
    duty_t r;
    duty_t g;
    duty_t b;
  } rgb_duty_t;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one colour channel. Holds the active duty and the registered
// PWM compare bit. The compare uses next-cycle values so the output changes
// in the same cycle the period counter does.
// With RGB_PWM_FADE_EN defined the channel also holds a target duty and the
// active duty steps by one toward it at every period boundary.
module pwm_channel
  import rgb_pkg::*;
#(
  parameter int W = PWM_BITS_DFLT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] duty_in,
`ifdef RGB_PWM_FADE_EN
  input  logic         boundary,
  output logic         settled,
`endif
  input  logic [W-1:0] cnt_next,
  output logic         pwm
);

  logic [W-1:0] active_q;
  logic [W-1:0] active_next;

`ifdef RGB_PWM_FADE_EN
  logic [W-1:0] target_q;

  // Step the active duty one count toward the target at each boundary.
  always_comb begin
    active_next = active_q;
    if (boundary) begin
      if (active_q < target_q) begin
        active_next = active_q + W'(1);
      end else if (active_q > target_q) begin
        active_next = active_q - W'(1);
      end
    end
  end

  // Accepted commands overwrite the target immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
    end else if (load) begin
      target_q <= duty_in;
    end
  end

  assign settled = (active_q == target_q);
`else
  // Without fading, the top strobes load only on a boundary with a pending
  // command, so the new duty lands exactly at the period start.
  always_comb begin
    active_next = active_q;
    if (load) begin
      active_next = duty_in;
    end
  end
`endif

  // Active duty and compare register; the compare sees the values that
  // will hold after this edge, so duty d gives exactly d high ticks from cnt=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      pwm      <= 1'b0;
    end else begin
      active_q <= active_next;
      pwm      <= (cnt_next < active_next);
    end
  end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: per-channel brightness stage in front of SB_RGBA_DRV.
// Accepts 8-bit R/G/B duties over valid/ready and drives glitch-free PWM bits,
// switching duties only at PWM period boundaries.
// Optional build macro RGB_PWM_FADE_EN: commands set per-channel targets and
// the active duties fade one step per period toward them.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_r/g/b are ignored on any other edge. cmd_ready
// does not depend on cmd_valid, and it is low while reset is high.
module rgb_pwm_ctrl
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DFLT,
  parameter int PRESC    = PRESC_DFLT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PWM_BITS-1:0] cmd_r,
  input  logic [PWM_BITS-1:0] cmd_g,
  input  logic [PWM_BITS-1:0] cmd_b,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic                period_start,
  output logic                busy
);

  logic [PRESC_W-1:0]  presc_q;
  logic                tick;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_next;
  logic                boundary;
  logic                accept;
  logic [PWM_BITS-1:0] cmd_duty [NUM_CH];
  logic [NUM_CH-1:0]   pwm_bits;

  // A tick is the prescaler's wrap cycle; with PRESC=1 every clk is a tick.
  assign tick     = (presc_q == PRESC_W'(PRESC - 1));
  assign boundary = tick && (cnt_q == {PWM_BITS{1'b1}});
  assign cnt_next = tick ? (cnt_q + PWM_BITS'(1)) : cnt_q;

  assign cmd_duty[CH_R] = cmd_r;
  assign cmd_duty[CH_G] = cmd_g;
  assign cmd_duty[CH_B] = cmd_b;

  // Prescaler: counts clk cycles and wraps on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // Period counter: advances on tick and wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

  // period_start is high for the one clk in which cnt has just become 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
    end
  end

`ifdef RGB_PWM_FADE_EN
  logic [NUM_CH-1:0] settled;

  assign cmd_ready = !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = !(&settled);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_channel #(.W(PWM_BITS)) u_channel (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .duty_in  (cmd_duty[ch]),
      .boundary (boundary),
      .settled  (settled[ch]),
      .cnt_next (cnt_next),
      .pwm      (pwm_bits[ch])
    );
  end
`else
  logic                pend_vld;
  logic [PWM_BITS-1:0] pend_duty [NUM_CH];
  logic                apply;

  assign cmd_ready = !reset && !pend_vld;
  assign accept    = cmd_valid && cmd_ready;
  // Only a command already pending at the start of the boundary cycle is
  // applied; one accepted on the boundary itself waits a full period.
  assign apply     = boundary && pend_vld;
  assign busy      = pend_vld;

  // Pending flag: set on accept, cleared when the command is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0;
    end else if (apply) begin
      pend_vld <= 1'b0;
    end else if (accept) begin
      pend_vld <= 1'b1;
    end
  end

  // Pending duties: captured on accept, dropped by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pend_duty[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pend_duty[i] <= cmd_duty[i];
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_channel #(.W(PWM_BITS)) u_channel (
      .clk      (clk),
      .reset    (reset),
      .load     (apply),
      .duty_in  (pend_duty[ch]),
      .cnt_next (cnt_next),
      .pwm      (pwm_bits[ch])
    );
  end
`endif

  assign pwm_r = pwm_bits[CH_R];
  assign pwm_g = pwm_bits[CH_G];
  assign pwm_b = pwm_bits[CH_B];

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb_rgb_pwm_ctrl: bench for rgb_pwm_ctrl. Two instances share the inputs:
// dut_a with PRESC=1 and dut_b with PRESC=3. A reference model derives the
// expected outputs from the clk count since reset with plain arithmetic.
// Build with RGB_PWM_FADE_EN defined to exercise the fade variant.
module tb_rgb_pwm_ctrl;

  localparam int PER = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_r = '0;
  logic [7:0] cmd_g = '0;
  logic [7:0] cmd_b = '0;

  logic ready_a, pr_a, pg_a, pb_a, ps_a, busy_a;
  logic ready_b, pr_b, pg_b, pb_b, ps_b, busy_b;

  rgb_pwm_ctrl #(.PWM_BITS(8), .PRESC(1)) u_dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
    .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b),
    .pwm_r(pr_a), .pwm_g(pg_a), .pwm_b(pb_a),
    .period_start(ps_a), .busy(busy_a)
  );

  rgb_pwm_ctrl #(.PWM_BITS(8), .PRESC(3)) u_dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
    .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b),
    .pwm_r(pr_b), .pwm_g(pg_b), .pwm_b(pb_b),
    .period_start(ps_b), .busy(busy_b)
  );

  // Clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_v;
  wire  [11:0] outs = {pr_a, pg_a, pb_a, ps_a, busy_a, ready_a,
                       pr_b, pg_b, pb_b, ps_b, busy_b, ready_b};

  // Reference model state, index 0 = dut_a, 1 = dut_b; channel 0=r,1=g,2=b.
  int clk_n[2];
  bit pend[2];
  int pend_d[2][3];
  int act[2][3];
  int tgt[2][3];
  int last_d[3];

  function automatic int presc_of(input int m);
    return (m == 0) ? 1 : 3;
  endfunction

  // Current period count of dut_a as seen by the model.
  function automatic int phase();
    return clk_n[0] % PER;
  endfunction

  // Advance the model by one clk edge using the inputs present at that edge.
  task automatic model_edge();
    logic [11:0] e;
    int d[3];
    e = '0;
    d[0] = int'(cmd_r);
    d[1] = int'(cmd_g);
    d[2] = int'(cmd_b);
    for (int m = 0; m < 2; m++) begin
      int p, cnt;
      bit tick, bnd, bsy, rdy, acc;
      logic [5:0] v;
      v = '0;
      if (reset) begin
        clk_n[m] = 0;
        pend[m] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          act[m][c] = 0; tgt[m][c] = 0; pend_d[m][c] = 0;
        end
      end else begin
        p = presc_of(m);
        tick = (clk_n[m] % p == p - 1);
        bnd = tick && ((clk_n[m] / p) % PER == PER - 1);
`ifdef RGB_PWM_FADE_EN
        if (bnd) begin
          for (int c = 0; c < 3; c++) begin
            if (act[m][c] < tgt[m][c]) act[m][c]++;
            else if (act[m][c] > tgt[m][c]) act[m][c]--;
          end
        end
        if (cmd_valid) begin
          for (int c = 0; c < 3; c++) tgt[m][c] = d[c];
        end
        bsy = 1'b0;
        for (int c = 0; c < 3; c++) if (act[m][c] != tgt[m][c]) bsy = 1'b1;
        rdy = 1'b1;
        acc = 1'b0;
`else
        acc = cmd_valid && !pend[m];
        if (bnd && pend[m]) begin
          for (int c = 0; c < 3; c++) act[m][c] = pend_d[m][c];
          pend[m] = 1'b0;
        end
        if (acc) begin
          for (int c = 0; c < 3; c++) pend_d[m][c] = d[c];
          pend[m] = 1'b1;
        end
        bsy = pend[m];
        rdy = !pend[m];
`endif
        clk_n[m]++;
        cnt = (clk_n[m] / p) % PER;
        v = {cnt < act[m][0], cnt < act[m][1], cnt < act[m][2], bnd, bsy, rdy};
      end
      if (m == 0) e[11:6] = v;
      else e[5:0] = v;
    end
    exp_q.push_back(e);
  endtask

  // Driver: one clk edge, model update, then settle for sampling.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input int r, input int g, input int b);
    cmd_valid = 1'b1;
    cmd_r = 8'(r);
    cmd_g = 8'(g);
    cmd_b = 8'(b);
  endtask

  task automatic test_reset();
    int first_ps = -1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL reset_vec i=%0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL post_reset_vec i=%0d outs=%b expected=%b", i, outs, exp_v);
      end
      if (ps_a === 1'b1 && first_ps < 0) first_ps = i + 1;
    end
    n_vec++;
    if (first_ps !== PER) begin
      n_err++;
      $display("FAIL first_period_start got=%0d required=%0d", first_ps, PER);
    end
    last_d = '{0, 0, 0};
  endtask

`ifndef RGB_PWM_FADE_EN
  // Send a command mid-period, then measure dut_a high time over nper periods.
  task automatic test_duty(input int r, input int g, input int b, input int nper);
    int want[3];
    int hc[3];
    bit sent = 1'b0;
    int done = 0;
    want = '{r, g, b};
    hc = '{0, 0, 0};
    for (int i = 0; i < (nper + 3) * PER && done < nper; i++) begin
      if (!sent && !pend[0] && phase() == 40) begin
        send(r, g, b);
        sent = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL duty_vec t=%0t outs=%b expected=%b", $time, outs, exp_v);
      end
      if (sent && !pend[0]) begin
        hc[0] += int'(pr_a);
        hc[1] += int'(pg_a);
        hc[2] += int'(pb_a);
        if (phase() == PER - 1) begin
          for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (hc[c] !== want[c]) begin
              n_err++;
              $display("FAIL duty_high ch=%0d period=%0d high=%0d required=%0d", c, done, hc[c], want[c]);
            end
          end
          hc = '{0, 0, 0};
          done++;
        end
      end
    end
    cmd_valid = 1'b0;
    n_vec++;
    if (done !== nper) begin
      n_err++;
      $display("FAIL duty_periods measured=%0d required=%0d", done, nper);
    end
    last_d = want;
  endtask

  // Command on the boundary cycle: next period keeps old duties, then new.
  task automatic test_boundary_cmd();
    int nw[3];
    int hc[3];
    int per = 0;
    bit sent = 1'b0;
    for (int c = 0; c < 3; c++) nw[c] = (last_d[c] + 1 + int'($urandom_range(0, 200))) % PER;
    hc = '{0, 0, 0};
    for (int i = 0; i < 4 * PER && per < 2; i++) begin
      if (!sent && !pend[0] && phase() == PER - 1) begin
        send(nw[0], nw[1], nw[2]);
        sent = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL boundary_vec t=%0t outs=%b expected=%b", $time, outs, exp_v);
      end
      if (sent) begin
        hc[0] += int'(pr_a);
        hc[1] += int'(pg_a);
        hc[2] += int'(pb_a);
        if (phase() == PER - 1) begin
          for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (hc[c] !== ((per == 0) ? last_d[c] : nw[c])) begin
              n_err++;
              $display("FAIL boundary_high ch=%0d period=%0d high=%0d required=%0d",
                       c, per, hc[c], (per == 0) ? last_d[c] : nw[c]);
            end
          end
          hc = '{0, 0, 0};
          per++;
        end
      end
    end
    cmd_valid = 1'b0;
    n_vec++;
    if (per !== 2) begin
      n_err++;
      $display("FAIL boundary_periods measured=%0d required=2", per);
    end
    last_d = nw;
  endtask

  // Reset with a command pending at cnt=100; nothing stale may appear after.
  task automatic test_reset_pending();
    bit sent = 1'b0;
    int hi = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      if (sent && pend[0] && phase() == 100) break;
      if (!sent && !pend[0] && phase() == 30) begin
        send($urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255));
        sent = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL rstpend_vec t=%0t outs=%b expected=%b", $time, outs, exp_v);
      end
    end
    reset = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 2 + 3 * PER; i++) begin
      if (i == 2) reset = 1'b0;
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL rstpend_after_vec i=%0d outs=%b expected=%b", i, outs, exp_v);
      end
      hi += int'(pr_a | pg_a | pb_a | busy_a);
    end
    n_vec++;
    if (hi !== 0) begin
      n_err++;
      $display("FAIL rstpend_stale high_or_busy_clks=%0d required=0", hi);
    end
    last_d = '{0, 0, 0};
  endtask
`endif

`ifdef RGB_PWM_FADE_EN
  // Fade 0 -> 3 on red, check per-period high time and busy, then retarget.
  task automatic test_fade();
    int ec[4];
    int hc = 0;
    int done = 0;
    bit sent = 1'b0;
    bit started = 1'b0;
    int hcs[3];
    ec = '{1, 2, 3, 3};
    reset = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL fade_reset_vec i=%0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 7 * PER && done < 4; i++) begin
      if (!sent && phase() == 20) begin
        send(3, 0, 0);
        sent = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL fade_vec t=%0t outs=%b expected=%b", $time, outs, exp_v);
      end
      if (sent && phase() == 0) started = 1'b1;
      if (started) begin
        if (phase() == 0) begin
          n_vec++;
          if (busy_a !== 1'(done < 2)) begin
            n_err++;
            $display("FAIL fade_busy period=%0d busy=%b required=%b", done, busy_a, 1'(done < 2));
          end
        end
        hc += int'(pr_a);
        if (phase() == PER - 1) begin
          n_vec++;
          if (hc !== ec[done]) begin
            n_err++;
            $display("FAIL fade_high period=%0d high=%0d required=%0d", done, hc, ec[done]);
          end
          hc = 0;
          done++;
        end
      end
    end
    // Retarget mid-period: busy rises at once, next period steps r 3->4, g 0->1.
    sent = 1'b0;
    started = 1'b0;
    done = 0;
    hcs = '{0, 0, 0};
    for (int i = 0; i < 3 * PER && done < 1; i++) begin
      if (!sent && phase() == 20) begin
        send(200, 5, 0);
        sent = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        n_vec++;
        if (busy_a !== 1'b1) begin
          n_err++;
          $display("FAIL fade_retarget_busy busy=%b required=1", busy_a);
        end
      end else begin
        cmd_valid = 1'b0;
        cycle();
      end
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL fade_retarget_vec t=%0t outs=%b expected=%b", $time, outs, exp_v);
      end
      if (sent && phase() == 0) started = 1'b1;
      if (started) begin
        hcs[0] += int'(pr_a);
        hcs[1] += int'(pg_a);
        hcs[2] += int'(pb_a);
        if (phase() == PER - 1) begin
          n_vec++;
          if (hcs[0] !== 4 || hcs[1] !== 1 || hcs[2] !== 0) begin
            n_err++;
            $display("FAIL fade_retarget_high r=%0d g=%0d b=%0d required r=4 g=1 b=0", hcs[0], hcs[1], hcs[2]);
          end
          done++;
        end
      end
    end
    n_vec++;
    if (done !== 1) begin
      n_err++;
      $display("FAIL fade_retarget_periods measured=%0d required=1", done);
    end
  endtask
`endif

  // Random commands, valid pulses and occasional resets against the model.
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) begin
        send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      end else begin
        cmd_valid = 1'b0;
        cmd_r = 8'($urandom_range(0, 255));
      end
      cycle();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL random_vec i=%0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // Watchdog: the sequence below is bounded, this only guards against a hang.
  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef RGB_PWM_FADE_EN
    test_fade();
    test_random();
`else
    test_duty(64, 128, 0, 2);
    test_duty(255, 255, 255, 2);
    test_duty(0, 255, $urandom_range(1, 254), 3);
    test_boundary_cmd();
    test_reset_pending();
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
